// File: rtl/pipe_ctrl.sv
// Hazard/stall controller for a 5-stage pipe: load-use interlock, EX redirect, DRAM wait with timeout.
// Latency: 0 (controls are combinational from state and inputs); backpressure: a DRAM wait freezes every stage.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  ex_rd,
  input  logic        ex_rf_we,
  input  logic        ex_is_load,
  input  logic [1:0]  ex_npc_op,
  input  logic        ex_br_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        id_ex_flush,
  output logic        ex_mem_stall,
  output logic        mem_wb_bubble,
  output logic        redirect,
  output logic        mem_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [0:0] {RUN, MEM_WAIT} state_t;

  state_t      state, state_nxt;
  logic [4:0]  wait_cnt, wait_cnt_nxt;
  logic        err_set;
  logic        mem_hold;
  logic        load_use;
  logic        taken;

  assign mem_hold = (state == MEM_WAIT) || ((state == RUN) && mem_req && !mem_ready);

  assign load_use = ex_is_load && ex_rf_we && (ex_rd != 5'd0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  assign taken = (ex_npc_op == 2'b01) || (ex_npc_op == 2'b10) ||
                 ((ex_npc_op == 2'b11) && ex_br_taken);

  // A pending EX redirect needs no storage: EX is frozen during the wait,
  // so taken re-appears on the first unheld cycle.
  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_stall  = 1'b0;
    mem_wb_bubble = 1'b0;
    redirect      = 1'b0;
    if (!rst) begin
      if (mem_hold) begin
        pc_stall      = 1'b1;
        if_id_stall   = 1'b1;
        id_ex_stall   = 1'b1;
        ex_mem_stall  = 1'b1;
        mem_wb_bubble = 1'b1;
      end else if (taken) begin
        redirect      = 1'b1;
        if_id_flush   = 1'b1;
        id_ex_flush   = 1'b1;
      end else if (load_use) begin
        pc_stall      = 1'b1;
        if_id_stall   = 1'b1;
        id_ex_flush   = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    err_set      = 1'b0;
    case (state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 5'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt    = RUN;
          wait_cnt_nxt = 5'd0;
        end else if (wait_cnt == 5'(MEM_TIMEOUT - 1)) begin
          // Forced release: the RUN-state entry cycle counts as the first held cycle.
          state_nxt    = RUN;
          wait_cnt_nxt = 5'd0;
          err_set      = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 5'd1;
        end
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= 5'd0;
      mem_err   <= 1'b0;
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      mem_err  <= mem_err | err_set;
      if (pc_stall) stall_cnt <= stall_cnt + 32'd1;
      if (redirect) flush_cnt <= flush_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: vector table for single-cycle decode, hand sequences for wait/timeout/reset.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_used, id_rs2_used, ex_rf_we, ex_is_load, ex_br_taken;
  logic [1:0]  ex_npc_op;
  logic        mem_req, mem_ready;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic        ex_mem_stall, mem_wb_bubble, redirect, mem_err;
  logic [31:0] stall_cnt, flush_cnt;

  pipe_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load),
    .ex_npc_op(ex_npc_op), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
    .mem_wb_bubble(mem_wb_bubble), .redirect(redirect), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_bubble, redirect}
  logic [7:0] ctrl;
  assign ctrl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                 id_ex_flush, ex_mem_stall, mem_wb_bubble, redirect};

  localparam logic [7:0] NONE  = 8'b0000_0000;
  localparam logic [7:0] LU    = 8'b1100_1000;
  localparam logic [7:0] REDIR = 8'b0010_1001;
  localparam logic [7:0] HOLD  = 8'b1101_0110;

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       we, ld;
    logic [1:0] npc;
    logic       br, mreq, mrdy;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[13];
  int   errors = 0;
  int   checks = 0;
  logic [31:0] exp_stall = 0;
  logic [31:0] exp_flush = 0;

  function automatic vec_t mk(logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                              logic [4:0] rd, logic we, logic ld, logic [1:0] npc,
                              logic br, logic mreq, logic mrdy, logic [7:0] exp);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd; v.we = we; v.ld = ld;
    v.npc = npc; v.br = br; v.mreq = mreq; v.mrdy = mrdy; v.exp = exp;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_rs1_used = v.u1; id_rs2_used = v.u2;
    ex_rd = v.rd; ex_rf_we = v.we; ex_is_load = v.ld; ex_npc_op = v.npc;
    ex_br_taken = v.br; mem_req = v.mreq; mem_ready = v.mrdy;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count_exp(input logic [7:0] e);
    if (e[7]) exp_stall = exp_stall + 32'd1;
    if (e[0]) exp_flush = exp_flush + 32'd1;
  endtask

  initial begin
    //            rs1   rs2   u1 u2 rd    we ld npc    br mreq mrdy exp
    vecs[0]  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 2'b00, 0, 0, 0, NONE);
    vecs[1]  = mk(5'd3, 5'd5, 1, 1, 5'd5, 1, 1, 2'b00, 0, 0, 0, LU);
    vecs[2]  = mk(5'd0, 5'd9, 1, 1, 5'd0, 1, 1, 2'b00, 0, 0, 0, NONE);
    vecs[3]  = mk(5'd7, 5'd2, 0, 1, 5'd7, 1, 1, 2'b00, 0, 0, 0, NONE);
    vecs[4]  = mk(5'd7, 5'd2, 1, 1, 5'd7, 0, 1, 2'b00, 0, 0, 0, NONE);
    vecs[5]  = mk(5'd7, 5'd2, 1, 1, 5'd7, 1, 0, 2'b00, 0, 0, 0, NONE);
    vecs[6]  = mk(5'd3, 5'd5, 1, 1, 5'd5, 1, 1, 2'b11, 1, 0, 0, REDIR);
    vecs[7]  = mk(5'd3, 5'd5, 1, 1, 5'd5, 1, 1, 2'b11, 0, 0, 0, LU);
    vecs[8]  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 2'b10, 0, 0, 0, REDIR);
    vecs[9]  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 2'b01, 0, 0, 0, REDIR);
    vecs[10] = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 2'b00, 1, 0, 0, NONE);
    vecs[11] = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 2'b10, 0, 1, 1, REDIR);
    vecs[12] = mk(5'd12, 5'd4, 1, 0, 5'd12, 1, 1, 2'b00, 0, 0, 0, LU);

    // Reset with hazard-inducing inputs: controls must be forced low.
    rst = 1'b1;
    apply(mk(5'd3, 5'd5, 1, 1, 5'd5, 1, 1, 2'b11, 1, 1, 0, NONE));
    step();
    step();
    chk("rst ctrl", 32'(ctrl), 32'(NONE));
    chk("rst stall_cnt", stall_cnt, 32'd0);
    chk("rst flush_cnt", flush_cnt, 32'd0);
    chk("rst mem_err", 32'(mem_err), 32'd0);
    apply(vecs[0]);
    rst = 1'b0;
    step();

    for (int i = 0; i < 13; i++) begin
      apply(vecs[i]);
      #2;
      chk($sformatf("vec%0d ctrl", i), 32'(ctrl), 32'(vecs[i].exp));
      count_exp(vecs[i].exp);
      step();
      chk($sformatf("vec%0d stall_cnt", i), stall_cnt, exp_stall);
      chk($sformatf("vec%0d flush_cnt", i), flush_cnt, exp_flush);
    end

    // DRAM wait of 4 held cycles with a jal pending in EX; redirect follows release.
    for (int c = 0; c < 4; c++) begin
      apply(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 2'b10, 0, 1, (c == 3) ? 1'b1 : 1'b0, NONE));
      #2;
      chk($sformatf("wait c%0d ctrl", c), 32'(ctrl), 32'(HOLD));
      count_exp(HOLD);
      step();
    end
    chk("wait stall_cnt", stall_cnt, exp_stall);
    apply(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 2'b10, 0, 0, 0, NONE));
    #2;
    chk("wait pending redirect", 32'(ctrl), 32'(REDIR));
    count_exp(REDIR);
    step();
    apply(vecs[0]);
    #2;
    chk("wait back to run", 32'(ctrl), 32'(NONE));
    chk("wait flush_cnt", flush_cnt, exp_flush);
    chk("wait no err", 32'(mem_err), 32'd0);
    step();

    // Timeout: exactly 16 held cycles, then mem_err sticks.
    for (int c = 1; c <= 16; c++) begin
      apply(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 2'b00, 0, 1, 0, NONE));
      #2;
      chk($sformatf("tmo c%0d ctrl", c), 32'(ctrl), 32'(HOLD));
      if (c == 16) chk("tmo err not early", 32'(mem_err), 32'd0);
      count_exp(HOLD);
      step();
    end
    apply(vecs[0]);
    #2;
    chk("tmo released", 32'(ctrl), 32'(NONE));
    chk("tmo mem_err", 32'(mem_err), 32'd1);
    chk("tmo stall_cnt", stall_cnt, exp_stall);
    step();
    step();
    chk("tmo mem_err sticky", 32'(mem_err), 32'd1);

    // Reset in the middle of a wait.
    for (int c = 0; c < 2; c++) begin
      apply(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 2'b00, 0, 1, 0, NONE));
      step();
    end
    rst = 1'b1;
    #2;
    chk("rstwait ctrl", 32'(ctrl), 32'(NONE));
    step();
    rst = 1'b0;
    apply(vecs[0]);
    #2;
    chk("rstwait run ctrl", 32'(ctrl), 32'(NONE));
    chk("rstwait stall_cnt", stall_cnt, 32'd0);
    chk("rstwait flush_cnt", flush_cnt, 32'd0);
    chk("rstwait mem_err", 32'(mem_err), 32'd0);
    step();
    apply(vecs[1]);
    #2;
    chk("rstwait lu after", 32'(ctrl), 32'(LU));
    step();
    chk("rstwait stall_cnt after", stall_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: maximum number of cycles in MEM_WAIT before a forced release.
REQ-002 SHALL have ports, in order:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- id_rs1  in  5  ID-stage source register 1.
- id_rs2  in  5  ID-stage source register 2.
- id_rs1_used  in  1  ID instruction reads rs1.
- id_rs2_used  in  1  ID instruction reads rs2.
- ex_rd  in  5  EX-stage destination register.
- ex_rf_we  in  1  EX instruction writes the register file.
- ex_is_load  in  1  EX instruction is a load.
- ex_npc_op  in  2  EX next-PC select: 00 seq, 01 jalr, 10 jal, 11 branch.
- ex_br_taken  in  1  EX branch condition true.
- mem_req  in  1  MEM-stage instruction accesses DRAM.
- mem_ready  in  1  DRAM access completes this cycle.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold IF/ID register.
- if_id_flush  out  1  zero IF/ID register (bubble).
- id_ex_stall  out  1  hold ID/EX register.
- id_ex_flush  out  1  zero ID/EX register.
- ex_mem_stall  out  1  hold EX/MEM register.
- mem_wb_bubble  out  1  insert bubble into MEM/WB.
- redirect  out  1  PC loads the EX target.
- mem_err  out  1  sticky flag: DRAM timeout occurred.
- stall_cnt  out  32  count of cycles with pc_stall=1.
- flush_cnt  out  32  count of redirect events.

Function
REQ-003 SHALL implement FSM states RUN and MEM_WAIT, plus a 5-bit wait counter wait_cnt.
REQ-004 SHALL define mem_hold = (state==MEM_WAIT) OR (state==RUN AND mem_req AND NOT mem_ready); it is a same-cycle (Mealy) decode.
REQ-005 SHALL, when mem_hold=1:
- drive pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_bubble to 1;
- drive redirect, if_id_flush and id_ex_flush to 0.
REQ-006 SHALL define load_use = ex_is_load AND ex_rf_we AND ex_rd!=0 AND ((id_rs1_used AND id_rs1==ex_rd) OR (id_rs2_used AND id_rs2==ex_rd)).
REQ-007 SHALL define taken = (ex_npc_op==01) OR (ex_npc_op==10) OR (ex_npc_op==11 AND ex_br_taken).
REQ-008 SHALL, when mem_hold=0 and taken=1, drive redirect=1, if_id_flush=1, id_ex_flush=1 and all stalls 0; redirect has priority over load_use.
REQ-009 SHALL, when mem_hold=0, taken=0 and load_use=1, drive pc_stall=1, if_id_stall=1 and id_ex_flush=1 for exactly that cycle; all other outputs 0.
REQ-010 SHALL drive all control outputs 0 when none of mem_hold, taken or load_use holds.
REQ-011 SHALL transition RUN->MEM_WAIT on mem_req AND NOT mem_ready, loading wait_cnt=1.
REQ-012 SHALL, in MEM_WAIT:
- on mem_ready=1, go to RUN and clear wait_cnt; that cycle is still held per REQ-004;
- otherwise increment wait_cnt.
REQ-013 SHALL, in MEM_WAIT with mem_ready=0 and wait_cnt==MEM_TIMEOUT-1, set mem_err=1, go to RUN and clear wait_cnt (forced release).
REQ-014 SHALL keep mem_err set until rst.
REQ-015 SHALL increment stall_cnt on each cycle with pc_stall=1, and flush_cnt on each cycle with redirect=1; both wrap from 0xFFFFFFFF to 0.
REQ-016 SHALL hold a pending EX redirect during MEM_WAIT (EX frozen) and assert it on the first cycle with mem_hold=0.
REQ-017 SHALL add no latency: all control outputs are combinational from the current state and inputs.

Reset
REQ-018 SHALL, on rst=1 at a clock edge: state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0, flush_cnt=0.
REQ-019 SHALL force all control outputs to 0 while rst=1, regardless of inputs.
REQ-020 SHALL, if rst is asserted mid MEM_WAIT, abandon the wait and start in RUN on the following cycle.

Verification
REQ-021 Load-use: ex_is_load=1, ex_rf_we=1, ex_rd=5, id_rs2=5, id_rs2_used=1 -> one cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1; stall_cnt 0->1.
REQ-022 x0 and unused source: ex_rd=0 with id_rs1=0, or id_rs1_used=0 with a matching register -> no stall.
REQ-023 Branch over load-use: ex_npc_op=11, ex_br_taken=1 with load_use also true -> redirect=1, both flushes=1, pc_stall=0; flush_cnt +1.
REQ-024 Memory wait: mem_req=1 with mem_ready=0 for 3 cycles, then 1 -> 4 consecutive cycles of full stall and bubble; RUN afterwards; stall_cnt +4.
REQ-025 Timeout: mem_req=1, mem_ready held 0 -> release after exactly 16 held cycles with mem_err=1; mem_err stays 1 until rst.
REQ-026 Reset mid-wait: rst during MEM_WAIT -> outputs 0, counters 0, RUN on the next cycle.
